// File: rtl/elastic_skp_scheduler.sv
// -----------------------------------------------------------------------------
// elastic_skp_scheduler
//
// Read-domain controller for the receive elastic buffer. Compares the buffer
// fill level against high/low thresholds and schedules a single SKP symbol
// delete (buffer too full) or add (buffer too empty) per incoming SKP ordered
// set, using a req/ack handshake with the buffer's insert/remove logic.
// Keeps sticky overflow/underflow status and, optionally, counts adjustments.
//
// Optional feature macro: ELASTIC_SKP_STATS_EN
//   defined   -> 8-bit saturating add_cnt/del_cnt counters are implemented
//   undefined -> no counter flops; add_cnt/del_cnt are tied to zero
//
// Ports
//   read_clk      in   single clock, all logic on its rising edge
//   rst           in   synchronous reset, active-high
//   enable        in   1 = new adjustments may be scheduled
//   occupancy     in   buffer fill level, 0..BUFFER_DEPTH
//   skp_window    in   high while the read side is inside a SKP ordered set
//   skp_len       in   SKP symbols seen so far in the current ordered set
//   adj_ack       in   buffer has performed the requested add/delete
//   clear_status  in   pulse that clears the sticky flags
//   add_req       out  request to insert one SKP symbol
//   delete_req    out  request to drop one SKP symbol
//   timeout_err   out  one-cycle pulse when a request is abandoned
//   ovf_sticky    out  set when the buffer is completely full
//   unf_sticky    out  set when the buffer is empty while enabled
//   add_cnt       out  saturating count of acknowledged adds
//   del_cnt       out  saturating count of acknowledged deletes
// -----------------------------------------------------------------------------
module elastic_skp_scheduler #(
  parameter  int BUFFER_DEPTH = 16,
  parameter  int HIGH_TH      = 12,
  parameter  int LOW_TH       = 4,
  parameter  int MIN_SKP      = 1,
  parameter  int MAX_SKP      = 5,
  parameter  int ACK_TIMEOUT  = 8,
  localparam int ADDR_W       = $clog2(BUFFER_DEPTH)
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W:0]   occupancy,
  input  logic              skp_window,
  input  logic [2:0]        skp_len,
  input  logic              adj_ack,
  input  logic              clear_status,
  output logic              add_req,
  output logic              delete_req,
  output logic              timeout_err,
  output logic              ovf_sticky,
  output logic              unf_sticky,
  output logic [7:0]        add_cnt,
  output logic [7:0]        del_cnt
);

  localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [ADDR_W:0] HIGH_V  = (ADDR_W+1)'(HIGH_TH);
  localparam logic [ADDR_W:0] LOW_V   = (ADDR_W+1)'(LOW_TH);
  localparam logic [ADDR_W:0] FULL_V  = (ADDR_W+1)'(BUFFER_DEPTH);
  localparam logic [2:0]      MIN_V   = 3'(MIN_SKP);
  localparam logic [2:0]      MAX_V   = 3'(MAX_SKP);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SKP = 2'd1,
    REQ      = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t            state;
  logic              dir_del;   // latched direction: 1 = delete, 0 = add
  logic [TMR_W-1:0]  timer;

  logic need_del;
  logic need_add;
  logic latched_need;
  logic limit_ok;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    need_del     = (occupancy >= HIGH_V);
    need_add     = (occupancy <= LOW_V);
    latched_need = dir_del ? need_del : need_add;
    // A delete must leave at least MIN_SKP symbols; an add must not exceed MAX_SKP.
    limit_ok     = dir_del ? (skp_len > MIN_V) : (skp_len < MAX_V);
  end

  // Scheduler FSM. The request outputs are registered and change only on
  // state transitions, so they are glitch-free toward the buffer logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      state       <= IDLE;
      dir_del     <= 1'b0;
      timer       <= '0;
      add_req     <= 1'b0;
      delete_req  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (need_add || need_del)) begin
            dir_del <= need_del;
            state   <= WAIT_SKP;
          end
        end

        WAIT_SKP: begin
          if (!enable || !latched_need) begin
            state <= IDLE;
          end else if (skp_window && limit_ok) begin
            state      <= REQ;
            timer      <= '0;
            add_req    <= !dir_del;
            delete_req <= dir_del;
          end
        end

        // enable is deliberately ignored here: an outstanding handshake
        // always finishes with either an ack or a timeout.
        REQ: begin
          if (adj_ack) begin
            state      <= HOLD;
            add_req    <= 1'b0;
            delete_req <= 1'b0;
          end else if (timer == TMO_LAST) begin
            state       <= IDLE;
            add_req     <= 1'b0;
            delete_req  <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Wait for the current ordered set to end so that at most one
        // adjustment is made per set.
        HOLD: begin
          if (!skp_window) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Sticky status: a set condition wins over clear_status in the same cycle.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (occupancy == FULL_V)            ovf_sticky <= 1'b1;
      else if (clear_status)              ovf_sticky <= 1'b0;

      if (enable && (occupancy == '0))    unf_sticky <= 1'b1;
      else if (clear_status)              unf_sticky <= 1'b0;
    end
  end

`ifdef ELASTIC_SKP_STATS_EN
  logic ack_fire;
  assign ack_fire = (state == REQ) && adj_ack;

  // Saturating counters; cleared only by reset, never by clear_status.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      add_cnt <= 8'd0;
      del_cnt <= 8'd0;
    end else if (ack_fire) begin
      if (dir_del) begin
        if (del_cnt != 8'hFF) del_cnt <= del_cnt + 8'd1;
      end else begin
        if (add_cnt != 8'hFF) add_cnt <= add_cnt + 8'd1;
      end
    end
  end
`else
  assign add_cnt = 8'd0;
  assign del_cnt = 8'd0;
`endif

endmodule
